// File: rtl/core_boot_loader.sv
// Boot loader: streams host words big-endian into byte-wide instruction RAM, initialises the
// branch predictor table, then sequences core reset hold/run/recapture. BHT init gated by BOOT_BHT_INIT_EN.
module core_boot_loader #(
    parameter int         NUM_WORDS_MAX    = 256,
    parameter int         IMEM_ADDR_W      = 10,
    parameter int         BHT_ENTRIES      = 16,
    parameter logic [1:0] BHT_INIT_VAL     = 2'b01,
    parameter int         RESET_HOLD       = 4,
    parameter int         RUN_CYC_PER_WORD = 5,
    localparam int        LEN_W            = $clog2(NUM_WORDS_MAX + 1),
    localparam int        IDX_W            = $clog2(BHT_ENTRIES)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LEN_W-1:0]       prog_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_word,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [7:0]             imem_wdata,
    output logic                   bht_we,
    output logic [IDX_W-1:0]       bht_idx,
    output logic [1:0]             bht_wdata,
    output logic                   core_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   run_timeout,
    output logic                   error,
    output logic [2:0]             state_dbg
);

    localparam int RUN_MAX  = NUM_WORDS_MAX * RUN_CYC_PER_WORD;
    localparam int CNT_MAX0 = (RUN_MAX > BHT_ENTRIES) ? RUN_MAX : BHT_ENTRIES;
    localparam int CNT_MAX  = (CNT_MAX0 > RESET_HOLD) ? CNT_MAX0 : RESET_HOLD;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_BHT  = 3'd2,
        S_HOLD = 3'd3,
        S_RUN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

`ifdef BOOT_BHT_INIT_EN
    localparam state_t AFTER_LOAD = S_BHT;
`else
    localparam state_t AFTER_LOAD = S_HOLD;
`endif

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] accepted;
    logic [LEN_W-1:0] w;
    logic [1:0]       bc;
    logic             buf_v;
    logic [31:0]      word_buf;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] budget;
    logic             hs;

    // Handshake: in_valid && in_ready transfers in_word on the rising edge. in_ready depends
    // only on registered state, never on in_valid.
    assign in_ready  = (state == S_LOAD) && (!buf_v || bc == 2'd3) && (accepted < len);
    assign hs        = in_valid && in_ready;
    assign imem_we   = (state == S_LOAD) && buf_v;
    assign imem_addr = IMEM_ADDR_W'({w, bc});
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    always_comb begin
        imem_wdata = 8'h00;
        case (bc)
            2'd0:    imem_wdata = word_buf[31:24];
            2'd1:    imem_wdata = word_buf[23:16];
            2'd2:    imem_wdata = word_buf[15:8];
            default: imem_wdata = word_buf[7:0];
        endcase
    end

`ifdef BOOT_BHT_INIT_EN
    assign bht_we    = (state == S_BHT);
    assign bht_idx   = cnt[IDX_W-1:0];
    assign bht_wdata = BHT_INIT_VAL;
`else
    assign bht_we    = 1'b0;
    assign bht_idx   = '0;
    assign bht_wdata = 2'b00;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            core_reset  <= 1'b1;
            error       <= 1'b0;
            run_timeout <= 1'b0;
            len         <= '0;
            accepted    <= '0;
            w           <= '0;
            bc          <= 2'd0;
            buf_v       <= 1'b0;
            word_buf    <= 32'h0;
            cnt         <= '0;
            budget      <= '0;
        end else begin
            run_timeout <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (prog_len > LEN_W'(NUM_WORDS_MAX)) begin
                            error <= 1'b1;
                        end else begin
                            error      <= 1'b0;
                            len        <= prog_len;
                            budget     <= (prog_len == '0) ? CNT_W'(RUN_CYC_PER_WORD)
                                          : CNT_W'(prog_len) * CNT_W'(RUN_CYC_PER_WORD);
                            accepted   <= '0;
                            w          <= '0;
                            bc         <= 2'd0;
                            buf_v      <= 1'b0;
                            cnt        <= '0;
                            core_reset <= 1'b1;
                            state      <= (prog_len == '0) ? AFTER_LOAD : S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (buf_v) begin
                        if (bc == 2'd3) begin
                            w     <= w + LEN_W'(1);
                            buf_v <= 1'b0;
                            if (w == len - LEN_W'(1)) begin
                                state <= AFTER_LOAD;
                            end
                        end else begin
                            bc <= bc + 2'd1;
                        end
                    end
                    // A new word may land in the same cycle the last byte of the previous one drains.
                    if (hs) begin
                        word_buf <= in_word;
                        buf_v    <= 1'b1;
                        bc       <= 2'd0;
                        accepted <= accepted + LEN_W'(1);
                    end
                end
                S_BHT: begin
                    if (cnt == CNT_W'(BHT_ENTRIES - 1)) begin
                        cnt   <= '0;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == CNT_W'(RESET_HOLD - 1)) begin
                        cnt        <= '0;
                        core_reset <= 1'b0;
                        state      <= S_RUN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (cnt == budget - CNT_W'(1)) begin
                        cnt         <= '0;
                        core_reset  <= 1'b1;
                        run_timeout <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_boot_loader.sv
// Directed bench for core_boot_loader: table of boot scenarios checked against a byte-write
// scoreboard and timing expectations, plus hand sequences for error and mid-load reset.
module tb_core_boot_loader;

    localparam int LEN_W      = 9;
    localparam int RESET_HOLD = 4;
`ifdef BOOT_BHT_INIT_EN
    localparam int EXP_BHT = 16;
`else
    localparam int EXP_BHT = 0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [8:0]   prog_len = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_word = 32'h0;
    logic         imem_we;
    logic [9:0]   imem_addr;
    logic [7:0]   imem_wdata;
    logic         bht_we;
    logic [3:0]   bht_idx;
    logic [1:0]   bht_wdata;
    logic         core_reset;
    logic         busy;
    logic         done;
    logic         run_timeout;
    logic         error;
    logic [2:0]   state_dbg;

    core_boot_loader dut (
        .clock(clock), .reset(reset), .start(start), .prog_len(prog_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .bht_we(bht_we), .bht_idx(bht_idx), .bht_wdata(bht_wdata),
        .core_reset(core_reset), .busy(busy), .done(done),
        .run_timeout(run_timeout), .error(error), .state_dbg(state_dbg)
    );

    // clock / cycle counter
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         len;
        logic [3:0] pat;
        int         exp_writes;
        int         exp_low;
        bit         pace;
    } vec_t;

    vec_t        tbl[5];
    logic [31:0] words[5];
    logic [17:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_imem"}, {13'd0, imem_we, imem_addr, imem_wdata}, 32'd0);
        check({tag, "_bht"}, {25'd0, bht_we, bht_idx, bht_wdata}, 32'd0);
        check({tag, "_status"}, {29'd0, busy, done, run_timeout}, 32'd0);
    endtask

    // Drives one boot and monitors it; returns early (hit=1) when abort_addr is written.
    task automatic run_boot(input int len, input logic [3:0] pat, input int exp_writes,
                            input int exp_low, input bit pace, input int abort_addr,
                            output bit hit);
        int nw = 0, nb = 0, nlow = 0, nto = 0, first_low = -1, last_wr = -1;
        int start_cyc, last_hs = -1, idx = 0, k = 0, iter = 0, exp_first;
        bit fin = 0;
        logic [31:0] wd;
        logic [17:0] e;
        hit = 0;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            wd = words[i];
            for (int b = 0; b < 4; b++) exp_q.push_back({10'(4 * i + b), wd[31 - 8 * b -: 8]});
        end
        @(negedge clock);
        prog_len = 9'(len);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        start_cyc = cyc;
        check("err_clear", 32'(error), 32'd0);
        while (!fin && iter < 3000) begin
            if (imem_we) begin
                nw++;
                last_wr = cyc;
                if (exp_q.size() == 0) check("imem_extra", {14'd0, imem_addr, imem_wdata}, 32'hffffffff);
                else begin
                    e = exp_q.pop_front();
                    check("imem_byte", {14'd0, imem_addr, imem_wdata}, {14'd0, e});
                end
                if (abort_addr >= 0 && imem_addr == 10'(abort_addr)) begin
                    in_valid = 1'b0;
                    hit = 1;
                    return;
                end
            end
            if (bht_we) begin
                check("bht_write", {26'd0, bht_idx, bht_wdata}, {26'd0, 4'(nb), 2'b01});
                nb++;
            end
            if (!core_reset) begin
                if (first_low < 0) first_low = cyc;
                nlow++;
            end
            if (run_timeout) nto++;
            if (done) fin = 1;
            if (!fin) begin
                if (idx < len) begin
                    in_valid = pat[3 - (k % 4)];
                    in_word = words[idx];
                    k++;
                    if (in_valid && in_ready) begin
                        if (pace && last_hs >= 0) check("hs_gap", 32'(cyc - last_hs), 32'd4);
                        last_hs = cyc;
                        idx++;
                    end
                end else begin
                    in_valid = 1'b0;
                end
                iter++;
                @(negedge clock);
            end
        end
        in_valid = 1'b0;
        check("boot_finished", 32'(fin), 32'd1);
        check("imem_count", 32'(nw), 32'(exp_writes));
        check("sb_left", 32'(exp_q.size()), 32'd0);
        check("bht_count", 32'(nb), 32'(EXP_BHT));
        check("run_low_cycles", 32'(nlow), 32'(exp_low));
        check("timeout_pulses", 32'(nto), 32'd1);
        exp_first = (len > 0) ? last_wr + 1 + EXP_BHT + RESET_HOLD : start_cyc + EXP_BHT + RESET_HOLD;
        check("release_cycle", 32'(first_low), 32'(exp_first));
        check("done_state", {29'd0, busy, core_reset, done}, 32'b011);
        @(negedge clock);
        check("timeout_one_cycle", {30'd0, run_timeout, done}, 32'b01);
    endtask

    initial begin
        bit hit;
        int nw;
        words[0] = 32'h00000000;
        words[1] = 32'h00500093;
        words[2] = 32'hfe209ce3;
        words[3] = 32'h12345678;
        words[4] = 32'hdeadbeef;
        tbl[0] = '{3, 4'b1111, 12, 15, 1'b1};
        tbl[1] = '{3, 4'b1001, 12, 15, 1'b0};
        tbl[2] = '{0, 4'b1111, 0, 5, 1'b0};
        tbl[3] = '{5, 4'b1011, 20, 25, 1'b0};
        tbl[4] = '{1, 4'b1111, 4, 5, 1'b0};

        repeat (2) @(negedge clock);
        check_reset_vals("rst_held");
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals("rst_idle");

        for (int v = 0; v < 5; v++)
            run_boot(tbl[v].len, tbl[v].pat, tbl[v].exp_writes, tbl[v].exp_low, tbl[v].pace, -1, hit);

        // oversize program: rejected, stays in DONE, nothing written
        @(negedge clock);
        prog_len = 9'd257;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("err_set", {29'd0, error, busy, done}, 32'b101);
        nw = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_we || bht_we) nw++;
            @(negedge clock);
        end
        check("err_no_writes", 32'(nw), 32'd0);
        check("err_sticky", 32'(error), 32'd1);
        run_boot(tbl[4].len, tbl[4].pat, tbl[4].exp_writes, tbl[4].exp_low, 1'b0, -1, hit);

        // reset while writing byte 1 of the second word, then reload from address 0
        run_boot(3, 4'b1111, 12, 15, 1'b0, 5, hit);
        check("abort_reached", 32'(hit), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_async");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_boot(tbl[0].len, tbl[0].pat, tbl[0].exp_writes, tbl[0].exp_low, 1'b1, -1, hit);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
